// File: rtl/nios2_debug_scan_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG scan master.
package nios2_debug_scan_pkg;

    localparam int DR_WIDTH_DEFAULT = 38;
    localparam int IR_WIDTH_DEFAULT = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SHIFT,
        UDR,
        RTI,
        RESP
    } scan_state_t;

endpackage

// File: rtl/nios2_debug_scan_tck_gen.sv
// Scan clock generator: tck low for the first TCK_DIV clk cycles of a period,
// high for the last TCK_DIV, running only while a scan is in progress.
module nios2_debug_scan_tck_gen
    import nios2_debug_scan_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  scan_state_t state,
    output logic        vji_tck,
    output logic        run_en,
    output logic        period_start,
    output logic        tck_rise
);

    localparam int CW = $clog2(2 * TCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] RISE = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt;

    assign run_en = (state != IDLE) && (state != RESP);
    // Asserted in the last clk cycle of a period: the next edge opens a new one.
    assign period_start = run_en && (cnt == LAST);
    assign tck_rise = run_en && (cnt == RISE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            vji_tck <= 1'b0;
        end else if (!run_en || period_start) begin
            cnt <= '0;
            vji_tck <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (tck_rise)
                vji_tck <= 1'b1;
        end
    end

endmodule

// File: rtl/nios2_debug_scan_master.sv
// Virtual-JTAG initiator for the Nios II debug slave: IR select plus one
// DR scan per command, captured tdo returned on a response channel.
module nios2_debug_scan_master
    import nios2_debug_scan_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int CW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    scan_state_t state, state_n;
    logic [DR_WIDTH-1:0] sr, sr_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [IR_WIDTH-1:0] ir_n;
    logic tdo_bit, tdi_n, uir_n, cdr_n, sdr_n, udr_n, rti_n, rsp_valid_n;
    logic run_en, period_start, tck_rise, accept;

    nios2_debug_scan_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk(clk),
        .reset(reset),
        .state(state),
        .vji_tck(vji_tck),
        .run_en(run_en),
        .period_start(period_start),
        .tck_rise(tck_rise)
    );

    assign cmd_ready = (state == IDLE);
    assign accept = cmd_valid && cmd_ready;
    assign rsp_data = sr;

    always_comb begin
        state_n = state;
        sr_n = sr;
        bit_cnt_n = bit_cnt;
        ir_n = vji_ir_in;
        tdi_n = vji_tdi;
        uir_n = vji_uir;
        cdr_n = vji_cdr;
        sdr_n = vji_sdr;
        udr_n = vji_udr;
        rti_n = vji_rti;
        rsp_valid_n = rsp_valid;
        unique case (state)
            IDLE: if (accept) begin
                state_n = UIR;
                sr_n = cmd_data;
                ir_n = cmd_ir;
                uir_n = 1'b1;
                rti_n = 1'b0;
            end
            UIR: if (period_start) begin
                state_n = CDR;
                uir_n = 1'b0;
                cdr_n = 1'b1;
            end
            CDR: if (period_start) begin
                state_n = SHIFT;
                cdr_n = 1'b0;
                sdr_n = 1'b1;
                bit_cnt_n = '0;
                tdi_n = sr[0];
            end
            SHIFT: if (period_start) begin
                sr_n = {tdo_bit, sr[DR_WIDTH-1:1]};
                if (bit_cnt == CW'(DR_WIDTH - 1)) begin
                    state_n = UDR;
                    sdr_n = 1'b0;
                    udr_n = 1'b1;
                    tdi_n = 1'b0;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    tdi_n = sr_n[0];
                end
            end
            UDR: if (period_start) begin
                state_n = RTI;
                udr_n = 1'b0;
                rti_n = 1'b1;
            end
            RTI: if (period_start) begin
                state_n = RESP;
                rsp_valid_n = 1'b1;
            end
            RESP: if (rsp_ready) begin
                state_n = IDLE;
                rsp_valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sr <= '0;
            bit_cnt <= '0;
            tdo_bit <= 1'b0;
            vji_tdi <= 1'b0;
            vji_ir_in <= '0;
            vji_uir <= 1'b0;
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b0;
            vji_udr <= 1'b0;
            vji_rti <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state <= state_n;
            sr <= sr_n;
            bit_cnt <= bit_cnt_n;
            vji_tdi <= tdi_n;
            vji_ir_in <= ir_n;
            vji_uir <= uir_n;
            vji_cdr <= cdr_n;
            vji_sdr <= sdr_n;
            vji_udr <= udr_n;
            vji_rti <= rti_n;
            rsp_valid <= rsp_valid_n;
            if (run_en && tck_rise)
                tdo_bit <= vji_tdo;
        end
    end

endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// Directed bench: one TCK_DIV=2 instance for scan/strobe/reset checks and a
// TCK_DIV=1 instance for back-to-back throughput.
module tb_nios2_debug_scan_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0] cmd_ir, ir_in;
    logic [37:0] cmd_data, rsp_data;
    logic tck, tdi, tdo, uir, cdr, sdr, udr, rti;
    logic loop, tdo_val;
    assign tdo = loop ? tdi : tdo_val;

    logic cmd_valid1, cmd_ready1, rsp_valid1;
    logic [1:0] cmd_ir1, ir_in1;
    logic [37:0] cmd_data1, rsp_data1;
    logic tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;

    nios2_debug_scan_master #(.TCK_DIV(2)) dut (
        .clk(clk), .reset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in),
        .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr),
        .vji_rti(rti)
    );

    nios2_debug_scan_master #(.TCK_DIV(1)) dut1 (
        .clk(clk), .reset(rst),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir1), .cmd_data(cmd_data1),
        .rsp_valid(rsp_valid1), .rsp_ready(1'b1), .rsp_data(rsp_data1),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdi1), .vji_ir_in(ir_in1),
        .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1),
        .vji_rti(rti1)
    );

    int n_vec = 0;
    int n_err = 0;

    int lat, n_uir, n_cdr, n_sdr, n_udr, rises, multi;
    int f_uir, f_cdr, f_sdr, f_udr, f_rti;
    logic ready_after;
    logic [37:0] got;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge with cmd_ready high; returns once rsp_valid is
    // seen (or the budget runs out) and leaves the response pending.
    task automatic scan(input logic [1:0] ir, input logic [37:0] d);
        logic ptck;
        int cyc;
        cmd_ir = ir;
        cmd_data = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ready_after = cmd_ready;
        cyc = 0;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; rises = 0; multi = 0;
        f_uir = -1; f_cdr = -1; f_sdr = -1; f_udr = -1; f_rti = -1;
        ptck = tck;
        while (!rsp_valid && cyc < 1000) begin
            if (uir) begin n_uir++; if (f_uir < 0) f_uir = cyc; end
            if (cdr) begin n_cdr++; if (f_cdr < 0) f_cdr = cyc; end
            if (sdr) begin n_sdr++; if (f_sdr < 0) f_sdr = cyc; end
            if (udr) begin n_udr++; if (f_udr < 0) f_udr = cyc; end
            if (rti && f_rti < 0) f_rti = cyc;
            if (tck && !ptck && sdr) rises++;
            if ($countones({uir, cdr, sdr, udr}) > 1) multi++;
            ptck = tck;
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc;
        got = rsp_data;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    int bad, na, nr, cyc1;
    int acc_t[2];
    int rsp_t[2];
    logic [37:0] rsp_d[2];
    logic pv_acc, prv;
    logic [37:0] held;

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
        loop = 1'b1; tdo_val = 1'b0;
        cmd_valid1 = 1'b0; cmd_ir1 = '0; cmd_data1 = '0;
        #1;
        chk("reset_ctl", {cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti},
            9'b1_0000_0001);
        chk("reset_data", rsp_data, 38'h0);
        chk("reset_ir", ir_in, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Loopback scan with strobe timing
        scan(2'b00, 38'h2A_5A5A_A5A5);
        chk("loop_ready_drop", ready_after, 1'b0);
        chk("loop_latency", lat, 168);
        chk("loop_data", got, 38'h2A_5A5A_A5A5);
        chk("uir_cycles", n_uir, 4);
        chk("uir_first", f_uir, 0);
        chk("cdr_cycles", n_cdr, 4);
        chk("cdr_first", f_cdr, 4);
        chk("sdr_cycles", n_sdr, 152);
        chk("sdr_first", f_sdr, 8);
        chk("sdr_tck_rises", rises, 38);
        chk("udr_cycles", n_udr, 4);
        chk("udr_first", f_udr, 160);
        chk("rti_after_udr", f_rti, 164);
        chk("one_hot_strobes", multi, 0);

        // Backpressure: response held for 50 cycles
        held = rsp_data;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (rsp_data !== held || tck !== 1'b0 || cmd_ready !== 1'b0 ||
                rsp_valid !== 1'b1 || rti !== 1'b1)
                bad++;
        end
        chk("bp_stable", bad, 0);
        release_rsp();
        chk("bp_release", {cmd_ready, rsp_valid}, 2'b10);

        // Constant tdo
        loop = 1'b0; tdo_val = 1'b1;
        scan(2'b11, 38'h12_3456_789A);
        chk("tdo1_data", got, 38'h3F_FFFF_FFFF);
        chk("tdo1_ir", ir_in, 2'b11);
        release_rsp();
        tdo_val = 1'b0;
        scan(2'b10, 38'h3F_0000_FFFF);
        chk("tdo0_data", got, 38'h0);
        chk("tdo0_latency", lat, 168);
        release_rsp();

        // Reset during shift bit 10
        loop = 1'b1;
        cmd_ir = 2'b01; cmd_data = 38'h15_5555_5555; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        bad = 0;
        while (!sdr && bad < 100) begin
            @(posedge clk); #1; bad++;
        end
        repeat (40) begin @(posedge clk); end
        #1;
        chk("mid_in_shift", sdr, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_reset_ctl",
            {cmd_ready, rsp_valid, tck, tdi, uir, cdr, sdr, udr, rti},
            9'b1_0000_0001);
        chk("mid_reset_data", {ir_in, rsp_data}, 40'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || udr || !cmd_ready) bad++;
        end
        chk("mid_no_partial", bad, 0);
        scan(2'b01, 38'h01_2345_6789);
        chk("post_reset_data", got, 38'h01_2345_6789);
        chk("post_reset_latency", lat, 168);
        release_rsp();

        // Back-to-back on the TCK_DIV=1 instance
        cmd_ir1 = 2'b10; cmd_data1 = 38'h15_0F0F_3C3C; cmd_valid1 = 1'b1;
        na = 0; nr = 0; cyc1 = 0; prv = 1'b0;
        pv_acc = cmd_valid1 && cmd_ready1;
        while (nr < 2 && cyc1 < 600) begin
            @(posedge clk); #1;
            cyc1++;
            if (pv_acc && na < 2) begin
                acc_t[na] = cyc1;
                na++;
                if (na == 1) begin
                    cmd_ir1 = 2'b01; cmd_data1 = 38'h0A_C3C3_9696;
                end else begin
                    cmd_valid1 = 1'b0;
                end
            end
            if (rsp_valid1 && !prv) begin
                rsp_t[nr] = cyc1;
                rsp_d[nr] = rsp_data1;
                nr++;
            end
            prv = rsp_valid1;
            pv_acc = cmd_valid1 && cmd_ready1;
        end
        chk("b2b_responses", nr, 2);
        chk("b2b_lat0", rsp_t[0] - acc_t[0], 84);
        chk("b2b_lat1", rsp_t[1] - acc_t[1], 84);
        chk("b2b_accept_gap", acc_t[1] - acc_t[0], 86);
        chk("b2b_data0", rsp_d[0], 38'h15_0F0F_3C3C);
        chk("b2b_data1", rsp_d[1], 38'h0A_C3C3_9696);
        @(posedge clk); @(posedge clk); #1;
        chk("b2b_ir_hold", {ir_in1, cmd_ready1}, 3'b011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nios2_debug_scan_master.md
Name: nios2_debug_scan_master

Overview:
Initiator side of the Nios II debug slave's virtual-JTAG interface. It drives the signal set the debug slave consumes: tck, tdi, ir_in, and the cdr/sdr/udr/uir/rti strobes. It also captures tdo. The block lets on-chip logic or a simulation bench issue IR-select plus 38-bit DR scans to the debug slave without the SLD hub. Scans are accepted on a valid/ready command channel, and captured data returns on a valid/ready response channel.

Parameters:
DR_WIDTH, 38, shift-register length in bits; matches the debug slave's sr/jdo width.
IR_WIDTH, 2, virtual IR width.
TCK_DIV, 2, clk cycles per tck half-period; legal range is at least 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  scan request valid
cmd_ready  out  1  block idle and able to accept a request
cmd_ir  in  IR_WIDTH  IR value presented during the scan
cmd_data  in  DR_WIDTH  DR value to shift in, LSB first
rsp_valid  out  1  captured data valid
rsp_ready  in  1  response consumed
rsp_data  out  DR_WIDTH  captured tdo bits; first-captured bit at bit 0
vji_tck  out  1  generated scan clock
vji_tdi  out  1  serial data to the slave
vji_tdo  in  1  serial data from the slave
vji_ir_in  out  IR_WIDTH  virtual IR value
vji_uir  out  1  update-IR state strobe
vji_cdr  out  1  capture-DR state strobe
vji_sdr  out  1  shift-DR state strobe
vji_udr  out  1  update-DR state strobe
vji_rti  out  1  run-test-idle indicator

Behaviour:
- Reset (async assert; all outputs take these values):
  - State IDLE; tck gen counter 0.
  - cmd_ready=1, rsp_valid=0, rsp_data=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - vji_uir=vji_cdr=vji_sdr=vji_udr=0, vji_rti=1.
- tck period:
  - One period is 2*TCK_DIV clk cycles: tck low for the first TCK_DIV cycles, high for the last TCK_DIV.
  - tck runs only in UIR, CDR, SHIFT, UDR and RTI. It is held low in IDLE and RESP.
- Timing within a period:
  - Registered strobes and tdi change only at period start (tck falling edge).
  - vji_tdo is sampled on the clk cycle where tck goes 0->1.
- Handshakes:
  - A command is accepted on a clk edge where cmd_valid && cmd_ready.
  - cmd_ir and cmd_data are latched at acceptance; cmd_ready drops the following cycle.
- FSM states, each one tck period unless noted:
  - IDLE: rti=1; on accept go to UIR.
  - UIR: vji_ir_in=latched IR, uir=1, rti=0; go to CDR.
  - CDR: cdr=1; go to SHIFT with bit count 0.
  - SHIFT: lasts DR_WIDTH periods with sdr=1.
    - vji_tdi = shift_reg[0] for the whole period.
    - At tck rise, tdo is captured.
    - At period end, shift_reg shifts right with the captured bit entering the MSB.
    - After period DR_WIDTH-1, go to UDR.
  - UDR: udr=1, tdi=0; go to RTI.
  - RTI: rti=1, all other strobes 0; go to RESP.
  - RESP: rsp_valid=1, rsp_data=shift_reg, rti=1.
    - On rsp_valid && rsp_ready, go to IDLE with cmd_ready=1 the next cycle.
    - With rsp_ready low, stay in RESP indefinitely: tck stays low, rsp_data is stable.
- Latency:
  - rsp_valid rises exactly (DR_WIDTH+4)*2*TCK_DIV clk cycles after the accepting edge; defaults give 168.
  - Back-to-back throughput is that value plus 2 cycles per scan when rsp_ready is tied 1.
- vji_ir_in holds the last scanned IR after the scan completes. It returns to 0 only on reset.
- Exactly one of uir/cdr/sdr/udr is high outside IDLE/RTI/RESP; none are high elsewhere.
- Reset mid-scan: asynchronous abort to the reset values. No partial rsp_valid is produced, and no udr pulse is emitted.
- cmd_valid while busy is ignored, and the command is not consumed.
- TCK_DIV=1: tck toggles every clk cycle and all rules above still hold.

Decomposition:
- Package nios2_debug_scan_pkg holds:
  - DR_WIDTH_DEFAULT=38, IR_WIDTH_DEFAULT=2.
  - IR codes: IR_OCIMEM=2'b00, IR_TRACEMEM=2'b01, IR_BREAK=2'b10, IR_TRACECTRL=2'b11.
  - FSM state enum scan_state_t {IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP}.
- One sub-module, nios2_debug_scan_tck_gen:
  - Contains the half-period counter and vji_tck.
  - Exports period_start, tck_rise and run_en pulses.
- The FSM, shift register and handshakes live in the top.

Test Plan:
- Reset values: assert reset mid-SHIFT (bit 10) -> all outputs return to reset values within the same cycle (async); no rsp_valid; next command completes normally.
- Loopback: vji_tdo tied to vji_tdi, cmd_ir=2'b00, cmd_data=38'h2A_5A5A_A5A5 -> rsp_data=38'h2A_5A5A_A5A5; rsp_valid 168 cycles after accept.
- Strobe ordering: one scan with TCK_DIV=2 -> checks below.
  - uir high for 4 cycles, then cdr for 4 cycles.
  - sdr for exactly 152 cycles, with exactly 38 tck rising edges while sdr=1.
  - udr for 4 cycles, then rti=1.
- Constant tdo: vji_tdo=1 -> rsp_data=38'h3F_FFFF_FFFF; vji_tdo=0 -> rsp_data=0.
- Backpressure: rsp_ready=0 for 50 cycles after rsp_valid -> rsp_data stable, vji_tck=0, cmd_ready=0; after rsp_ready=1, cmd_ready=1 on the following cycle.
- Back-to-back with TCK_DIV=1: two commands with IR 2'b10 then 2'b01 and rsp_ready tied 1 -> two responses 84 cycles apart from their accepts; vji_ir_in=2'b01 afterwards.
